// File: rtl/aes_pkg.sv
// Shared definitions for the AES plaintext feed path:
// block geometry, padding schemes and packer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_W     = 128;

    localparam int PAD_PKCS7 = 0;
    localparam int PAD_FIXED = 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        OUT  = 2'd2
    } packState_t;

    // fillCount is the number of message bytes already in the block (1..16)
    function automatic logic [7:0] padValue(
        input int         mode,
        input logic [4:0] fillCount,
        input logic [7:0] padChar
    );
        if (mode == PAD_FIXED) begin
            return padChar;
        end
        return 8'(5'd16 - fillCount);
    endfunction

endpackage

// File: rtl/aes_pad_fill.sv
// Overwrites every byte slot at or beyond fillCount with padByte.
// Slot 0 is the most significant byte of the block.
module aes_pad_fill
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] blockIn,
    input  logic [4:0]             fillCount,
    input  logic [7:0]             padByte,
    output logic [AES_BLOCK_W-1:0] blockOut
);

    logic [AES_BLOCK_BYTES-1:0] slotMask;

    always_comb begin
        slotMask = '0;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            slotMask[i] = (5'(i) >= fillCount);
        end
    end

    always_comb begin
        blockOut = '0;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            blockOut[AES_BLOCK_W-1-8*i -: 8] = slotMask[i] ? padByte
                : blockIn[AES_BLOCK_W-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a byte stream into padded 128-bit AES plaintext blocks,
// first byte in bits [127:120], with a valid/ready block output.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int         PAD_MODE = 0,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready
);

    localparam bit IS_PKCS7 = (PAD_MODE == PAD_PKCS7);

    packState_t             state;
    packState_t             nextState;
    logic [3:0]             cnt;
    logic [AES_BLOCK_W-1:0] blockReg;
    logic [AES_BLOCK_W-1:0] paddedBlock;
    logic                   lastFlag;
    logic                   extraPending;
    logic                   accept;
    logic [7:0]             padByte;

    assign accept  = in_valid && in_ready;
    // In PAD, cnt already holds the number of filled bytes
    assign padByte = padValue(PAD_MODE, {1'b0, cnt}, PAD_CHAR);

    aes_pad_fill padFill (
        .blockIn   (blockReg),
        .fillCount ({1'b0, cnt}),
        .padByte   (padByte),
        .blockOut  (paddedBlock)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            FILL: begin
                if (accept && cnt == 4'd15) begin
                    nextState = OUT;
                end else if (accept && in_last) begin
                    nextState = PAD;
                end
            end
            PAD: begin
                nextState = OUT;
            end
            OUT: begin
                if (out_ready && !extraPending) begin
                    nextState = FILL;
                end
            end
            default: begin
                nextState = FILL;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
            end
            PAD: begin
                in_ready = 1'b0;
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = lastFlag;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blockReg     <= '0;
            cnt          <= '0;
            lastFlag     <= 1'b0;
            extraPending <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        blockReg[{~cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            // PKCS#7 owes a whole pad block after a full last block
                            lastFlag     <= in_last && !IS_PKCS7;
                            extraPending <= in_last && IS_PKCS7;
                        end
                    end
                end
                PAD: begin
                    blockReg <= paddedBlock;
                    lastFlag <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        cnt <= '0;
                        if (extraPending) begin
                            blockReg     <= {AES_BLOCK_BYTES{8'h10}};
                            extraPending <= 1'b0;
                            lastFlag     <= 1'b1;
                        end else begin
                            lastFlag <= 1'b0;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign out_block = blockReg;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: instance 0 uses PKCS#7, instance 1
// fixed fill; output blocks are scored against a queue of expected blocks.
module tb_aes_block_packer;

    logic              clk;
    logic [1:0]        rst;
    logic [1:0][7:0]   inData;
    logic [1:0]        inValid;
    logic [1:0]        inLast;
    logic [1:0]        inReady;
    logic [1:0][127:0] outBlock;
    logic [1:0]        outValid;
    logic [1:0]        outLast;
    logic [1:0]        outReady;

    logic [128:0] expQ0[$];
    logic [128:0] expQ1[$];
    int vectors;
    int miscompares;

    aes_block_packer #(.PAD_MODE(0), .PAD_CHAR(8'h20)) dutPkcs (
        .clk(clk), .rst(rst[0]),
        .in_data(inData[0]), .in_valid(inValid[0]), .in_last(inLast[0]),
        .in_ready(inReady[0]), .out_block(outBlock[0]),
        .out_valid(outValid[0]), .out_last(outLast[0]),
        .out_ready(outReady[0])
    );

    aes_block_packer #(.PAD_MODE(1), .PAD_CHAR(8'h20)) dutFixed (
        .clk(clk), .rst(rst[1]),
        .in_data(inData[1]), .in_valid(inValid[1]), .in_last(inLast[1]),
        .in_ready(inReady[1]), .out_block(outBlock[1]),
        .out_valid(outValid[1]), .out_last(outLast[1]),
        .out_ready(outReady[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [128:0] obs,
                         input logic [128:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst[0] && outValid[0] && outReady[0]) begin
            check("q0 pending", 129'(expQ0.size() != 0), 129'd1);
            if (expQ0.size() != 0) begin
                check("blk0", {outLast[0], outBlock[0]}, expQ0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst[1] && outValid[1] && outReady[1]) begin
            check("q1 pending", 129'(expQ1.size() != 0), 129'd1);
            if (expQ1.size() != 0) begin
                check("blk1", {outLast[1], outBlock[1]}, expQ1.pop_front());
            end
        end
    end

    task automatic sendByte(input int m, input logic [7:0] b, input logic last);
        int n;
        inData[m]  = b;
        inLast[m]  = last;
        inValid[m] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!inReady[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("in_ready timeout", 129'(n), 129'd0);
        end
        @(posedge clk);
        #1;
        inValid[m] = 1'b0;
        inLast[m]  = 1'b0;
    endtask

    task automatic sendStr(input int m, input string s, input bit lastAtEnd);
        for (int i = 0; i < s.len(); i++) begin
            sendByte(m, s[i], lastAtEnd && (i == s.len() - 1));
        end
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        rst      = 2'b11;
        inData   = '0;
        inValid  = '0;
        inLast   = '0;
        outReady = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;

        for (int m = 0; m < 2; m++) begin
            check("rst in_ready", 129'(inReady[m]), 129'd1);
            check("rst out_valid", 129'(outValid[m]), 129'd0);
            check("rst out_last", 129'(outLast[m]), 129'd0);
            check("rst out_block", 129'(outBlock[m]), 129'd0);
        end

        // full block, no last, fixed mode
        expQ1.push_back({1'b0, 128'h54686520717569636b2062726f776e20});
        sendStr(1, "The quick brown ", 0);
        check("lat16 valid", 129'(outValid[1]), 129'd1);
        check("lat16 in_ready", 129'(inReady[1]), 129'd0);

        // partial block, fixed fill
        expQ1.push_back({1'b1, 128'h746865206c617a7920646f672e202020});
        sendStr(1, "the lazy dog.", 1);
        check("pad cycle valid", 129'(outValid[1]), 129'd0);
        check("pad cycle ready", 129'(inReady[1]), 129'd0);
        @(posedge clk);
        #1;
        check("pad lat valid", 129'(outValid[1]), 129'd1);
        check("pad lat last", 129'(outLast[1]), 129'd1);

        // full last block in fixed mode: no extra block
        expQ1.push_back({1'b1, 128'h54686520717569636b2062726f776e20});
        sendStr(1, "The quick brown ", 1);

        // backpressure
        @(posedge clk);
        #1;
        outReady[1] = 1'b0;
        expQ1.push_back({1'b0, 128'h4142434445464748494a4b4c4d4e4f50});
        sendStr(1, "ABCDEFGHIJKLMNOP", 0);
        inData[1]  = 8'h51;
        inValid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold blk", {outLast[1], outBlock[1]},
                  {1'b0, 128'h4142434445464748494a4b4c4d4e4f50});
            check("hold in_ready", 129'(inReady[1]), 129'd0);
            check("hold valid", 129'(outValid[1]), 129'd1);
            @(posedge clk);
            #1;
        end
        inValid[1]  = 1'b0;
        outReady[1] = 1'b1;
        @(posedge clk);
        #1;
        check("release valid", 129'(outValid[1]), 129'd0);
        check("release in_ready", 129'(inReady[1]), 129'd1);
        expQ1.push_back({1'b0, 128'h5152535455565758595a616263646566});
        sendStr(1, "QRSTUVWXYZabcdef", 0);

        // PKCS#7 partial block
        expQ0.push_back({1'b1, 128'h746865206c617a7920646f672e030303});
        sendStr(0, "the lazy dog.", 1);

        // PKCS#7 full last block: data block then all-0x10 block
        expQ0.push_back({1'b0, 128'h666f78206a756d706564206f76657220});
        expQ0.push_back({1'b1, {16{8'h10}}});
        sendStr(0, "fox jumped over ", 1);
        check("pkcs full valid", 129'(outValid[0]), 129'd1);
        check("pkcs full last", 129'(outLast[0]), 129'd0);

        // PKCS#7 single-byte message pads 15 bytes of 0x0f
        expQ0.push_back({1'b1, 128'h5a0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f});
        sendStr(0, "Z", 1);

        // reset mid-message discards the partial block
        sendStr(0, "garbage", 0);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check("midrst in_ready", 129'(inReady[0]), 129'd1);
        check("midrst out_valid", 129'(outValid[0]), 129'd0);
        expQ0.push_back({1'b0, 128'h30313233343536373839616263646566});
        sendStr(0, "0123456789abcdef", 0);

        n = 0;
        while ((expQ0.size() != 0 || expQ1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", 129'(expQ0.size() + expQ1.size()), 129'd0);
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
- Upstream feeder for the aes128 encryption pipeline.
- Accepts a message as a byte stream with a valid/ready handshake.
- Assembles bytes into 128-bit plaintext blocks, MSB-first: the first byte goes in bits [127:120]. The message "The quick brown " yields 128'h54686520717569636b2062726f776e20.
- Pads the final block (PKCS#7 or fixed fill character) and presents each block on a valid/ready output that drives the aes128 plaintext input.

Parameters:
PAD_MODE, 0, padding scheme: 0 = PKCS#7; 1 = fixed fill with PAD_CHAR.
PAD_CHAR, 8'h20, fill byte used when PAD_MODE = 1 (ASCII space).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
in_data  in  8  message byte.
in_valid  in  1  in_data is valid.
in_last  in  1  qualifies in_data as the final byte of the message.
in_ready  out  1  packer can accept a byte this cycle.
out_block  out  128  assembled plaintext block, feeds aes128 plainText.
out_valid  out  1  out_block is valid.
out_last  out  1  out_block is the final block of the message.
out_ready  in  1  consumer takes out_block this cycle.

Behaviour:
- Single clock domain clk. rst is synchronous and active-high.
- Reset values: state = FILL, byte count = 0, out_block = 0, out_valid = 0, out_last = 0, in_ready = 1 in the cycle after reset.
- A byte is accepted when in_valid && in_ready. The accepted byte is written at bit slot [127-8*cnt -: 8], then cnt increments (4-bit counter, 0..15).
- States:
  - FILL
    - in_ready = 1.
    - Accepted byte with cnt = 15 (block full): go to OUT; last_flag = in_last. In PKCS#7 mode only, in_last also sets extra_pending = 1.
    - Accepted byte with in_last and cnt < 15: go to PAD; r = cnt+1 bytes filled.
  - PAD (exactly 1 cycle, in_ready = 0)
    - Fills every byte slot >= r in a single cycle.
    - PKCS#7: fill value = 16-r.
    - Fixed mode: fill value = PAD_CHAR.
    - Then go to OUT with last_flag = 1.
  - OUT
    - out_valid = 1 and in_ready = 0; out_block and out_last are held stable until out_ready.
    - On out_ready: cnt = 0.
    - If extra_pending = 1: load 16 bytes of 8'h10, clear extra_pending, stay in OUT with out_last = 1.
    - Otherwise go to FILL.
- out_last = last_flag while in OUT. The full-block-with-in_last case in PKCS#7 therefore emits two blocks: the first with out_last = 0, the second (all 8'h10) with out_last = 1.
- Latency:
  - 16th byte accepted at edge t → out_valid = 1 from t+1.
  - Partial final block: last byte at t → PAD at t+1 → out_valid = 1 from t+2.
  - Sustained throughput: 16 bytes plus 1 handshake cycle per block, since the output register is not double-buffered.
- Boundary conditions:
  - in_last with cnt = 15 in fixed mode: no padding and no extra block.
  - Zero-length messages are not supported; a message is at least one byte.
  - in_last without in_valid is ignored.
  - in_valid while in_ready = 0 is not accepted; the upstream source holds the byte.
  - out_ready while out_valid = 0 has no effect.
  - rst asserted mid-message or in PAD/OUT: the partial block, extra_pending and last_flag are discarded, and the next cycle is in FILL with cnt = 0.
  - The held out_block register is not cleared on leaving OUT; its contents are don't-care while out_valid = 0.
- Downstream note: aes128 has a fixed 21-cycle latency and no valid input. The consumer must delay out_valid/out_last by 21 cycles alongside the cipher; this is outside this block.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_BYTES = 16, AES_BLOCK_W = 128.
  - PAD_PKCS7 = 0, PAD_FIXED = 1.
  - State encoding: FILL, PAD, OUT.
- One natural combinational sub-module, aes_pad_fill. Inputs: block, fill count r, pad byte. Output: the padded block, built from a per-byte mask of slots >= r. It is reusable by the decryption-side unpadder for checking padding.

Test Plan:
1. PAD_MODE = 1: stream "The quick brown " (16 bytes, no last) → out_valid one cycle after the 16th byte; out_block = 54686520717569636b2062726f776e20, out_last = 0.
2. PAD_MODE = 1: "the lazy dog." (13 bytes, in_last on '.') → after one PAD cycle, out_block = 746865206c617a7920646f672e202020, out_last = 1.
3. PAD_MODE = 0: same 13 bytes → out_block = 746865206c617a7920646f672e030303, out_last = 1.
4. PAD_MODE = 0: "fox jumped over " with in_last on byte 16 → block 666f78206a756d706564206f76657220 with out_last = 0, then block 10101010101010101010101010101010 with out_last = 1.
5. Backpressure: hold out_ready = 0 for 5 cycles during OUT → out_block stable, in_ready = 0, no bytes accepted; one out_ready cycle releases and returns to FILL.
6. Assert rst for one cycle after 7 bytes → next cycle in_ready = 1, out_valid = 0. A following 16-byte block must contain only the new bytes.
